hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/sat_counter.sv | 24 ++
 rtl/hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: NOP encoding, hazard FSM state encoding, counter width
// and the load-use detection helper.
package riscv_pkg;

   localparam logic [31:0] NOP_INSN = 32'h00000013;
   localparam int          CNT_W    = 16;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      DFREEZE = 2'd2
   } hz_state_t;

   // rd=x0 is never a real destination, so it can never cause a load-use hit.
   function automatic logic load_use_hit(input logic       mem_read,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic       use1,
                                         input logic [4:0] rs2,
                                         input logic       use2);
      return mem_read && (rd != 5'd0) &&
             ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_ctrl_if;
   import riscv_pkg::*;

   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic [4:0]       ex_rd;
   logic             ex_mem_read;
   logic             ex_branch_taken;
   // imem_valid qualifies fetch data in the cycle it is high; there is no ready back to
   // the fetch side, a missing word is absorbed by holding the PC and bubbling IF/ID.
   logic             imem_valid;
   logic             dmem_busy;
   logic             cnt_clr;
   logic             pc_en;
   logic             q1q2_en;
   logic             q1q2_flush;
   logic             q2q3_en;
   logic             q2q3_flush;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, imem_valid, dmem_busy, cnt_clr,
      input  pc_en, q1q2_en, q1q2_flush, q2q3_en, q2q3_flush, state_o,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, imem_valid, dmem_busy, cnt_clr,
      output pc_en, q1q2_en, q1q2_flush, q2q3_en, q2q3_flush, state_o,
             stall_cnt, flush_cnt
   );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; a synchronous clear beats a same-cycle increment.
module sat_counter
   import riscv_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: boot flush, data-memory freeze, branch redirect, load-use and
// fetch-miss stalls, plus stall/flush performance counters.
module hazard_ctrl
   import riscv_pkg::*;
(
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);

   hz_state_t state;
   logic      boot_cnt;
   logic      branch_pending;
   logic      run_eval;
   logic      freeze;
   logic      redirect;
   logic      load_use;
   logic      stall_ev;
   logic      pc_en_c, q1q2_en_c, q1q2_flush_c, q2q3_en_c, q2q3_flush_c;

   // A DFREEZE cycle with dmem_busy low is already treated as a RUN cycle.
   always_comb begin
      load_use = load_use_hit(hz.ex_mem_read, hz.ex_rd, hz.id_rs1, hz.id_uses_rs1,
                              hz.id_rs2, hz.id_uses_rs2);
      run_eval = (state != BOOT) && !hz.dmem_busy;
      freeze   = (state != BOOT) && hz.dmem_busy;
      redirect = run_eval && (hz.ex_branch_taken || branch_pending);
      stall_ev = run_eval && !redirect && (load_use || !hz.imem_valid);
   end

   always_comb begin
      pc_en_c      = 1'b0;
      q1q2_en_c    = 1'b0;
      q1q2_flush_c = 1'b0;
      q2q3_en_c    = 1'b0;
      q2q3_flush_c = 1'b0;
      if (!rst_n) begin
         q1q2_flush_c = 1'b1;
         q2q3_flush_c = 1'b1;
      end else if (state == BOOT) begin
         q1q2_en_c    = 1'b1;
         q1q2_flush_c = 1'b1;
         q2q3_en_c    = 1'b1;
         q2q3_flush_c = 1'b1;
      end else if (freeze) begin
         pc_en_c = 1'b0;
      end else if (redirect) begin
         pc_en_c      = 1'b1;
         q1q2_en_c    = 1'b1;
         q1q2_flush_c = 1'b1;
         q2q3_en_c    = 1'b1;
         q2q3_flush_c = 1'b1;
      end else if (load_use) begin
         q2q3_en_c    = 1'b1;
         q2q3_flush_c = 1'b1;
      end else if (!hz.imem_valid) begin
         q1q2_en_c    = 1'b1;
         q1q2_flush_c = 1'b1;
         q2q3_en_c    = 1'b1;
      end else begin
         pc_en_c   = 1'b1;
         q1q2_en_c = 1'b1;
         q2q3_en_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= BOOT;
         boot_cnt       <= 1'b0;
         branch_pending <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               boot_cnt <= ~boot_cnt;
               if (boot_cnt) state <= RUN;
            end
            RUN, DFREEZE: begin
               if (hz.dmem_busy) begin
                  state <= DFREEZE;
                  // A branch resolved during the freeze must not be lost.
                  if (hz.ex_branch_taken) branch_pending <= 1'b1;
               end else begin
                  state          <= RUN;
                  branch_pending <= 1'b0;
               end
            end
            default: begin
               state          <= BOOT;
               boot_cnt       <= 1'b0;
               branch_pending <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (hz.cnt_clr),
      .inc   (stall_ev),
      .cnt   (hz.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (hz.cnt_clr),
      .inc   (redirect),
      .cnt   (hz.flush_cnt)
   );

   assign hz.pc_en      = pc_en_c;
   assign hz.q1q2_en    = q1q2_en_c;
   assign hz.q1q2_flush = q1q2_flush_c;
   assign hz.q2q3_en    = q2q3_en_c;
   assign hz.q2q3_flush = q2q3_flush_c;
   assign hz.state_o    = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each cycle's expected controls/state/counters go into a
// queue; a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;
   import riscv_pkg::*;

   // ctrl bits: {pc_en, q1q2_en, q1q2_flush, q2q3_en, q2q3_flush}
   localparam logic [4:0] C_RST   = 5'b00101;
   localparam logic [4:0] C_BOOT  = 5'b01111;
   localparam logic [4:0] C_FRZ   = 5'b00000;
   localparam logic [4:0] C_REDIR = 5'b11111;
   localparam logic [4:0] C_LU    = 5'b00011;
   localparam logic [4:0] C_IMISS = 5'b01110;
   localparam logic [4:0] C_NORM  = 5'b11010;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [38:0] exp_q[$];
   string       name_q[$];

   hazard_ctrl_if hz();

   hazard_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic set_in(input logic br, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic iv, input logic busy, input logic clr);
      hz.ex_branch_taken = br;
      hz.ex_mem_read     = mr;
      hz.ex_rd           = rd;
      hz.id_rs1          = rs1;
      hz.id_uses_rs1     = u1;
      hz.id_rs2          = rs2;
      hz.id_uses_rs2     = u2;
      hz.imem_valid      = iv;
      hz.dmem_busy       = busy;
      hz.cnt_clr         = clr;
   endtask

   task automatic idle_in();
      set_in(1'b0, 1'b0, 5'd3, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic cyc(input string nm, input logic [4:0] ctrl, input logic [1:0] st,
                      input logic [15:0] sc, input logic [15:0] fc);
      exp_q.push_back({ctrl, st, sc, fc});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [38:0] e;
         string       nm;
         logic [4:0]  got_ctrl;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         got_ctrl = {hz.pc_en, hz.q1q2_en, hz.q1q2_flush, hz.q2q3_en, hz.q2q3_flush};
         total++;
         if ({got_ctrl, hz.state_o} !== e[38:32]) begin
            bad++;
            $display("FAIL %s ctrl/state: got ctrl=%b st=%0d, exp ctrl=%b st=%0d",
                     nm, got_ctrl, hz.state_o, e[38:34], e[33:32]);
         end
         total++;
         if ({hz.stall_cnt, hz.flush_cnt} !== e[31:0]) begin
            bad++;
            $display("FAIL %s counters: got stall=%h flush=%h, exp stall=%h flush=%h",
                     nm, hz.stall_cnt, hz.flush_cnt, e[31:16], e[15:0]);
         end
      end
   end

   // stimulus
   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle_in();
      @(posedge clk);
      #1;

      cyc("reset0", C_RST, 2'd0, 16'd0, 16'd0);
      cyc("reset1", C_RST, 2'd0, 16'd0, 16'd0);

      rst_n = 1'b1;
      cyc("boot1", C_BOOT, 2'd0, 16'd0, 16'd0);
      cyc("boot2", C_BOOT, 2'd0, 16'd0, 16'd0);
      cyc("run_first", C_NORM, 2'd1, 16'd0, 16'd0);

      set_in(1'b0, 1'b1, 5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("lu_rs2", C_LU, 2'd1, 16'd0, 16'd0);
      idle_in();
      cyc("lu_done", C_NORM, 2'd1, 16'd1, 16'd0);

      set_in(1'b0, 1'b1, 5'd0, 5'd1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("lu_x0", C_NORM, 2'd1, 16'd1, 16'd0);
      set_in(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("lu_rs1", C_LU, 2'd1, 16'd1, 16'd0);
      set_in(1'b0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("lu_rs1_unused", C_NORM, 2'd1, 16'd2, 16'd0);

      set_in(1'b1, 1'b1, 5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("br_over_lu", C_REDIR, 2'd1, 16'd2, 16'd0);
      idle_in();
      hz.cnt_clr = 1'b1;
      cyc("clr", C_NORM, 2'd1, 16'd2, 16'd1);
      hz.cnt_clr = 1'b0;

      set_in(1'b1, 1'b0, 5'd3, 5'd1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("frz_br1", C_FRZ, 2'd1, 16'd0, 16'd0);
      cyc("frz_br2", C_FRZ, 2'd2, 16'd0, 16'd0);
      cyc("frz_br3", C_FRZ, 2'd2, 16'd0, 16'd0);
      idle_in();
      cyc("pending_apply", C_REDIR, 2'd2, 16'd0, 16'd0);
      cyc("pending_clear", C_NORM, 2'd1, 16'd0, 16'd1);

      hz.imem_valid = 1'b0;
      cyc("imiss1", C_IMISS, 2'd1, 16'd0, 16'd1);
      cyc("imiss2", C_IMISS, 2'd1, 16'd1, 16'd1);
      hz.imem_valid = 1'b1;
      cyc("imiss_done", C_NORM, 2'd1, 16'd2, 16'd1);

      hz.dmem_busy = 1'b1;
      cyc("frz_plain", C_FRZ, 2'd1, 16'd2, 16'd1);
      hz.dmem_busy = 1'b0;
      cyc("frz_release", C_NORM, 2'd2, 16'd2, 16'd1);
      cyc("frz_back_run", C_NORM, 2'd1, 16'd2, 16'd1);

      hz.dmem_busy = 1'b1;
      cyc("frz_a", C_FRZ, 2'd1, 16'd2, 16'd1);
      cyc("frz_b", C_FRZ, 2'd2, 16'd2, 16'd1);
      rst_n = 1'b0;
      cyc("reset_mid_frz", C_RST, 2'd0, 16'd0, 16'd0);
      rst_n = 1'b1;
      cyc("reboot1", C_BOOT, 2'd0, 16'd0, 16'd0);
      cyc("reboot2", C_BOOT, 2'd0, 16'd0, 16'd0);
      cyc("reboot_frz", C_FRZ, 2'd1, 16'd0, 16'd0);
      hz.dmem_busy = 1'b0;
      cyc("reboot_rel", C_NORM, 2'd2, 16'd0, 16'd0);

      hz.imem_valid = 1'b0;
      for (int i = 0; i < 65534; i++) begin
         cyc("sat_fill", C_IMISS, 2'd1, 16'(i), 16'd0);
      end
      cyc("sat_fffe", C_IMISS, 2'd1, 16'hFFFE, 16'd0);
      cyc("sat_ffff", C_IMISS, 2'd1, 16'hFFFF, 16'd0);
      cyc("sat_hold", C_IMISS, 2'd1, 16'hFFFF, 16'd0);
      hz.imem_valid = 1'b1;
      cyc("sat_check", C_NORM, 2'd1, 16'hFFFF, 16'd0);
      hz.imem_valid = 1'b0;
      hz.cnt_clr    = 1'b1;
      cyc("clr_vs_inc", C_IMISS, 2'd1, 16'hFFFF, 16'd0);
      hz.imem_valid = 1'b1;
      hz.cnt_clr    = 1'b0;
      cyc("clr_result", C_NORM, 2'd1, 16'd0, 16'd0);

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending entries, exp 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
